// File: rtl/vital_alarm_monitor_if.sv
// ============================================================================
// Module      : vital_alarm_monitor_if
// Description : Sample/acknowledge inputs and alarm status outputs of the
//               vital-sign alarm monitor, bundled for port connection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vital_alarm_monitor_if;
    // Comparator sample and operator acknowledge
    logic       sample_valid;
    logic       lo_Lt;
    logic       lo_Et;
    logic       lo_Gt;
    logic       hi_Lt;
    logic       hi_Et;
    logic       hi_Gt;
    logic       ack;

    // Alarm status
    logic       alarm;
    logic       alarm_low;
    logic       alarm_high;
    logic [1:0] state;
    logic       fault;
    logic [7:0] event_cnt;

    // Sample source / status consumer
    modport master (
        output sample_valid, lo_Lt, lo_Et, lo_Gt, hi_Lt, hi_Et, hi_Gt, ack,
        input  alarm, alarm_low, alarm_high, state, fault, event_cnt
    );

    // The monitor itself
    modport slave (
        input  sample_valid, lo_Lt, lo_Et, lo_Gt, hi_Lt, hi_Et, hi_Gt, ack,
        output alarm, alarm_low, alarm_high, state, fault, event_cnt
    );
endinterface

`default_nettype wire

// File: rtl/vital_alarm_monitor.sv
// ============================================================================
// Module      : vital_alarm_monitor
// Description : Persistence-filtered out-of-range alarm with acknowledge,
//               sticky comparator-fault flag and saturating event counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vital_alarm_monitor #(
    parameter int PERSIST = 3
) (
    input  wire                  clk,
    input  wire                  rst,
    vital_alarm_monitor_if.slave bus
);

    localparam logic [1:0] c_st_normal = 2'b00;
    localparam logic [1:0] c_st_pend   = 2'b01;
    localparam logic [1:0] c_st_alarm  = 2'b10;
    localparam logic [1:0] c_st_hold   = 2'b11;

    localparam logic [3:0] c_persist   = PERSIST[3:0];
    localparam logic       c_dir_low   = 1'b0;
    localparam logic       c_dir_high  = 1'b1;

    logic [1:0] r_state;
    logic [3:0] r_pcnt;
    logic       r_dir;
    logic       r_alarm;
    logic       r_alarm_low;
    logic       r_alarm_high;
    logic       r_fault;
    logic [7:0] r_event_cnt;

    logic       w_lo_onehot;
    logic       w_hi_onehot;
    logic       w_is_low;
    logic       w_is_high;
    logic       w_fault;
    logic       w_oor;
    logic       w_in;
    logic       w_sdir;
    logic [3:0] w_pcnt_inc;

    logic [1:0] w_next_state;
    logic [3:0] w_next_pcnt;
    logic       w_next_dir;
    logic       w_event;

    // Sample classification; a malformed comparator result is ignored by the FSM
    always_comb begin
        w_lo_onehot = ({bus.lo_Lt, bus.lo_Et, bus.lo_Gt} == 3'b100) ||
                      ({bus.lo_Lt, bus.lo_Et, bus.lo_Gt} == 3'b010) ||
                      ({bus.lo_Lt, bus.lo_Et, bus.lo_Gt} == 3'b001);
        w_hi_onehot = ({bus.hi_Lt, bus.hi_Et, bus.hi_Gt} == 3'b100) ||
                      ({bus.hi_Lt, bus.hi_Et, bus.hi_Gt} == 3'b010) ||
                      ({bus.hi_Lt, bus.hi_Et, bus.hi_Gt} == 3'b001);
        w_is_low    = bus.lo_Lt;
        w_is_high   = bus.hi_Gt;
        w_fault     = bus.sample_valid &
                      (~w_lo_onehot | ~w_hi_onehot | (w_is_low & w_is_high));
        w_oor       = bus.sample_valid & ~w_fault & (w_is_low | w_is_high);
        w_in        = bus.sample_valid & ~w_fault & ~w_is_low & ~w_is_high;
        w_sdir      = w_is_high ? c_dir_high : c_dir_low;
        w_pcnt_inc  = r_pcnt + 4'd1;
    end

    // Next-state, persistence and direction decision
    always_comb begin
        w_next_state = r_state;
        w_next_pcnt  = r_pcnt;
        w_next_dir   = r_dir;
        w_event      = 1'b0;
        case (r_state)
            c_st_normal: begin
                if (w_oor) begin
                    w_next_dir  = w_sdir;
                    w_next_pcnt = 4'd1;
                    if (c_persist == 4'd1) begin
                        w_next_state = c_st_alarm;
                        w_event      = 1'b1;
                    end else begin
                        w_next_state = c_st_pend;
                    end
                end
            end
            c_st_pend: begin
                if (w_oor) begin
                    if (w_sdir == r_dir) begin
                        w_next_pcnt = w_pcnt_inc;
                        if (w_pcnt_inc == c_persist) begin
                            w_next_state = c_st_alarm;
                            w_event      = 1'b1;
                        end
                    end else begin
                        w_next_pcnt = 4'd1;
                        w_next_dir  = w_sdir;
                    end
                end else if (w_in) begin
                    w_next_state = c_st_normal;
                    w_next_pcnt  = 4'd0;
                end
            end
            c_st_alarm: begin
                if (w_oor) begin
                    w_next_dir = w_sdir;
                end else if (w_in) begin
                    w_next_state = c_st_hold;
                end
            end
            default: begin
                // HOLD: a fresh excursion takes priority over the acknowledge
                if (w_oor) begin
                    w_next_state = c_st_alarm;
                    w_next_dir   = w_sdir;
                end else if (bus.ack) begin
                    w_next_state = c_st_normal;
                    w_next_pcnt  = 4'd0;
                end
            end
        endcase
    end

    // State, status outputs, fault flag and event counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_normal;
            r_pcnt       <= 4'd0;
            r_dir        <= c_dir_low;
            r_alarm      <= 1'b0;
            r_alarm_low  <= 1'b0;
            r_alarm_high <= 1'b0;
            r_fault      <= 1'b0;
            r_event_cnt  <= 8'd0;
        end else begin
            r_state      <= w_next_state;
            r_pcnt       <= w_next_pcnt;
            r_dir        <= w_next_dir;
            r_alarm      <= w_next_state[1];
            r_alarm_low  <= w_next_state[1] & (w_next_dir == c_dir_low);
            r_alarm_high <= w_next_state[1] & (w_next_dir == c_dir_high);
            if (w_fault) begin
                r_fault <= 1'b1;
            end else if (bus.ack) begin
                r_fault <= 1'b0;
            end
            if (w_event && (r_event_cnt != 8'hFF)) begin
                r_event_cnt <= r_event_cnt + 8'd1;
            end
        end
    end

    assign bus.state      = r_state;
    assign bus.alarm      = r_alarm;
    assign bus.alarm_low  = r_alarm_low;
    assign bus.alarm_high = r_alarm_high;
    assign bus.fault      = r_fault;
    assign bus.event_cnt  = r_event_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vital_alarm_monitor.sv
// ============================================================================
// Module      : tb_vital_alarm_monitor
// Description : Directed self-checking bench for vital_alarm_monitor with
//               PERSIST=3 and PERSIST=1 instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vital_alarm_monitor;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    vital_alarm_monitor_if bus3 ();
    vital_alarm_monitor_if bus1 ();

    vital_alarm_monitor #(.PERSIST(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    vital_alarm_monitor #(.PERSIST(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample kinds
    localparam int K_IDLE  = 0;  // sample_valid = 0
    localparam int K_LOW   = 1;  // below low threshold
    localparam int K_HIGH  = 2;  // above high threshold
    localparam int K_IN    = 3;  // strictly between thresholds
    localparam int K_EQLO  = 4;  // equal to low threshold
    localparam int K_EQHI  = 5;  // equal to high threshold
    localparam int K_BADLO = 6;  // lo_Lt and lo_Et both set
    localparam int K_BOTH  = 7;  // LOW and HIGH simultaneously
    localparam int K_NOHI  = 8;  // hi triple all zero

    task automatic set_bus(input int which, input int kind, input logic a);
        logic [6:0] v;  // {valid, lo_Lt, lo_Et, lo_Gt, hi_Lt, hi_Et, hi_Gt}
        case (kind)
            K_LOW:   v = 7'b1_100_100;
            K_HIGH:  v = 7'b1_001_001;
            K_IN:    v = 7'b1_001_100;
            K_EQLO:  v = 7'b1_010_100;
            K_EQHI:  v = 7'b1_001_010;
            K_BADLO: v = 7'b1_110_100;
            K_BOTH:  v = 7'b1_100_001;
            K_NOHI:  v = 7'b1_001_000;
            default: v = 7'b0_000_000;
        endcase
        if (which == 3) begin
            {bus3.sample_valid, bus3.lo_Lt, bus3.lo_Et, bus3.lo_Gt,
             bus3.hi_Lt, bus3.hi_Et, bus3.hi_Gt} = v;
            bus3.ack = a;
            {bus1.sample_valid, bus1.lo_Lt, bus1.lo_Et, bus1.lo_Gt,
             bus1.hi_Lt, bus1.hi_Et, bus1.hi_Gt} = 7'd0;
            bus1.ack = 1'b0;
        end else begin
            {bus1.sample_valid, bus1.lo_Lt, bus1.lo_Et, bus1.lo_Gt,
             bus1.hi_Lt, bus1.hi_Et, bus1.hi_Gt} = v;
            bus1.ack = a;
            {bus3.sample_valid, bus3.lo_Lt, bus3.lo_Et, bus3.lo_Gt,
             bus3.hi_Lt, bus3.hi_Et, bus3.hi_Gt} = 7'd0;
            bus3.ack = 1'b0;
        end
    endtask

    // Present one input pattern, then move to 1 time unit after the edge
    task automatic step(input int which, input int kind, input logic a);
        set_bus(which, kind, a);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check dut3's externally visible status in one call
    task automatic chk3(input string tag, input logic [1:0] st, input logic al,
                        input logic alo, input logic ahi, input logic flt,
                        input logic [7:0] ev);
        chk({tag, ".state"}, 32'(bus3.state), 32'(st));
        chk({tag, ".alarm"}, 32'(bus3.alarm), 32'(al));
        chk({tag, ".alarm_low"}, 32'(bus3.alarm_low), 32'(alo));
        chk({tag, ".alarm_high"}, 32'(bus3.alarm_high), 32'(ahi));
        chk({tag, ".fault"}, 32'(bus3.fault), 32'(flt));
        chk({tag, ".event_cnt"}, 32'(bus3.event_cnt), 32'(ev));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        set_bus(3, K_HIGH, 1'b0);   // reset must override a live sample
        @(posedge clk);
        #1;
        step(3, K_HIGH, 1'b0);
        chk3("reset", 2'b00, 0, 0, 0, 0, 8'd0);
        chk("reset.pcnt", 32'(dut3.r_pcnt), 32'd0);
        chk("reset.dut1.state", 32'(bus1.state), 32'd0);
        chk("reset.dut1.event_cnt", 32'(bus1.event_cnt), 32'd0);
        rst = 1'b0;

        // Three HIGH samples reach ALARM on the third edge
        step(3, K_HIGH, 1'b0);
        chk3("high1", 2'b01, 0, 0, 0, 0, 8'd0);
        chk("high1.pcnt", 32'(dut3.r_pcnt), 32'd1);
        step(3, K_HIGH, 1'b0);
        chk3("high2", 2'b01, 0, 0, 0, 0, 8'd0);
        step(3, K_HIGH, 1'b0);
        chk3("high3", 2'b10, 1, 0, 1, 0, 8'd1);

        // ALARM follows direction changes; ack ignored in ALARM
        step(3, K_LOW, 1'b1);
        chk3("alarm_flip", 2'b10, 1, 1, 0, 0, 8'd1);
        step(3, K_IN, 1'b0);
        chk3("to_hold", 2'b11, 1, 1, 0, 0, 8'd1);
        step(3, K_HIGH, 1'b1);
        chk3("hold_reentry", 2'b10, 1, 0, 1, 0, 8'd1);
        step(3, K_IN, 1'b0);
        chk3("hold2", 2'b11, 1, 0, 1, 0, 8'd1);
        step(3, K_IDLE, 1'b0);
        chk3("hold_idle", 2'b11, 1, 0, 1, 0, 8'd1);
        step(3, K_IDLE, 1'b1);
        chk3("hold_ack", 2'b00, 0, 0, 0, 0, 8'd1);
        chk("hold_ack.pcnt", 32'(dut3.r_pcnt), 32'd0);

        // LOW, LOW, IN, LOW, LOW never alarms
        step(3, K_LOW, 1'b0);
        step(3, K_LOW, 1'b0);
        chk("low2.pcnt", 32'(dut3.r_pcnt), 32'd2);
        step(3, K_IN, 1'b0);
        chk3("low_in", 2'b00, 0, 0, 0, 0, 8'd1);
        chk("low_in.pcnt", 32'(dut3.r_pcnt), 32'd0);
        step(3, K_LOW, 1'b0);
        step(3, K_LOW, 1'b0);
        chk3("low_low", 2'b01, 0, 0, 0, 0, 8'd1);
        chk("low_low.pcnt", 32'(dut3.r_pcnt), 32'd2);
        step(3, K_HIGH, 1'b0);
        chk3("opposite", 2'b01, 0, 0, 0, 0, 8'd1);
        chk("opposite.pcnt", 32'(dut3.r_pcnt), 32'd1);
        step(3, K_HIGH, 1'b0);
        chk("pend2.pcnt", 32'(dut3.r_pcnt), 32'd2);

        // Reset mid-PEND, then a single HIGH sample
        rst = 1'b1;
        step(3, K_HIGH, 1'b0);
        chk3("rst_pend", 2'b00, 0, 0, 0, 0, 8'd0);
        chk("rst_pend.pcnt", 32'(dut3.r_pcnt), 32'd0);
        rst = 1'b0;
        step(3, K_HIGH, 1'b0);
        chk3("post_rst", 2'b01, 0, 0, 0, 0, 8'd0);
        step(3, K_IN, 1'b0);

        // Equality with either threshold counts as in-range
        step(3, K_EQLO, 1'b0);
        chk3("eq_low", 2'b00, 0, 0, 0, 0, 8'd0);
        step(3, K_EQHI, 1'b0);
        chk3("eq_high", 2'b00, 0, 0, 0, 0, 8'd0);

        // Fault handling
        step(3, K_LOW, 1'b0);
        step(3, K_BADLO, 1'b0);
        chk3("fault_set", 2'b01, 0, 0, 0, 1, 8'd0);
        chk("fault_set.pcnt", 32'(dut3.r_pcnt), 32'd1);
        step(3, K_IDLE, 1'b1);
        chk3("fault_ack", 2'b01, 0, 0, 0, 0, 8'd0);
        step(3, K_BOTH, 1'b1);
        chk3("fault_ack_same", 2'b01, 0, 0, 0, 1, 8'd0);
        step(3, K_NOHI, 1'b0);
        chk3("fault_nohi", 2'b01, 0, 0, 0, 1, 8'd0);
        step(3, K_IDLE, 1'b1);
        chk3("fault_clr", 2'b01, 0, 0, 0, 0, 8'd0);
        step(3, K_LOW, 1'b0);
        chk("low_after_fault.pcnt", 32'(dut3.r_pcnt), 32'd2);
        step(3, K_LOW, 1'b0);
        chk3("low_alarm", 2'b10, 1, 1, 0, 0, 8'd1);
        step(3, K_IDLE, 1'b1);
        chk3("alarm_ack_ignored", 2'b10, 1, 1, 0, 0, 8'd1);

        // PERSIST=1: direct NORMAL->ALARM, event counter saturates
        step(1, K_HIGH, 1'b0);
        chk("p1.state", 32'(bus1.state), 32'd2);
        chk("p1.alarm_high", 32'(bus1.alarm_high), 32'd1);
        chk("p1.event_cnt", 32'(bus1.event_cnt), 32'd1);
        step(1, K_IN, 1'b0);
        step(1, K_IDLE, 1'b1);
        chk("p1.normal", 32'(bus1.state), 32'd0);
        for (int i = 1; i < 256; i++) begin
            step(1, K_HIGH, 1'b0);
            step(1, K_IN, 1'b0);
            step(1, K_IDLE, 1'b1);
        end
        chk("p1.sat_event_cnt", 32'(bus1.event_cnt), 32'd255);
        chk("p1.sat_state", 32'(bus1.state), 32'd0);
        step(1, K_HIGH, 1'b0);
        chk("p1.sat_hold", 32'(bus1.event_cnt), 32'd255);
        // dut3 untouched while its inputs were idle
        chk3("dut3_idle_hold", 2'b10, 1, 1, 0, 0, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
